// File: rtl/arcade_input_cond.sv
// arcade_input_cond
//   Conditions raw player inputs ahead of the core's active-low in0/in1 packing.
//   Debounces N_IN general lines, turns each of two coin switches into one
//   fixed-length pulse per physical insertion, and keeps a saturating coin count.
//
// Ports
//   CLK         system clock (only clock of the block)
//   RESET       synchronous reset, active-high
//   in_raw      asynchronous active-high buttons/directions
//   coin_raw    asynchronous active-high coin switches
//   coin_lock   per-channel lockout, 1 = reject new coins
//   out_db      debounced general inputs, active-high
//   coin_pulse  conditioned coin pulses, active-high
//   coin_busy   coin channel not idle
//   coin_count  total accepted coins over both channels, saturating
module arcade_input_cond #(
    parameter int unsigned N_IN     = 8,
    parameter int unsigned TICK_DIV = 24000,
    parameter int unsigned DB_MS    = 10,
    parameter int unsigned COIN_MS  = 100,
    parameter int unsigned GAP_MS   = 100
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [N_IN-1:0] in_raw,
    input  logic [1:0]      coin_raw,
    input  logic [1:0]      coin_lock,
    output logic [N_IN-1:0] out_db,
    output logic [1:0]      coin_pulse,
    output logic [1:0]      coin_busy,
    output logic [15:0]     coin_count
);

    // General inputs occupy the low bits, coin lines the top two.
    localparam int unsigned NB   = N_IN + 2;
    localparam int unsigned PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DW   = $clog2(DB_MS + 1);
    localparam int unsigned CMAX = (COIN_MS > GAP_MS) ? COIN_MS : GAP_MS;
    localparam int unsigned CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StGap,
        StWaitRel
    } coin_st_t;

    // ---------------------------------------------------------------------
    // 2-FF synchronisers
    // ---------------------------------------------------------------------
    logic [NB-1:0] sync1_q;
    logic [NB-1:0] sync2_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {coin_raw, in_raw};
            sync2_q <= sync1_q;
        end
    end

    // ---------------------------------------------------------------------
    // Timebase
    // ---------------------------------------------------------------------
    logic [PW-1:0] presc_q;
    logic          tick;

    assign tick = (presc_q == PW'(TICK_DIV - 1));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

    // ---------------------------------------------------------------------
    // Debounce, one stability counter per line
    // ---------------------------------------------------------------------
    logic [NB-1:0] db_q;
    logic [DW-1:0] db_cnt_q [NB];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            db_q <= '0;
            for (int i = 0; i < NB; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (sync2_q[i] == db_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (tick) begin
                    // The increment that would reach DB_MS commits the new value instead.
                    if (db_cnt_q[i] == DW'(DB_MS - 1)) begin
                        db_q[i]     <= sync2_q[i];
                        db_cnt_q[i] <= '0;
                    end else begin
                        db_cnt_q[i] <= db_cnt_q[i] + DW'(1);
                    end
                end
            end
        end
    end

    assign out_db = db_q[N_IN-1:0];

    // ---------------------------------------------------------------------
    // Coin channels
    // ---------------------------------------------------------------------
    logic [1:0]    cd;
    logic [1:0]    cd_prev_q;
    logic [1:0]    accept;
    coin_st_t      st_q   [2];
    logic [CW-1:0] tcnt_q [2];
    logic [1:0]    pulse_q;
    logic [1:0]    busy_q;

    assign cd = db_q[N_IN +: 2];

    always_comb begin
        accept = '0;
        for (int c = 0; c < 2; c++) begin
            accept[c] = (st_q[c] == StIdle) && cd[c] && !cd_prev_q[c] && !coin_lock[c];
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cd_prev_q <= '0;
            pulse_q   <= '0;
            busy_q    <= '0;
            for (int c = 0; c < 2; c++) begin
                st_q[c]   <= StIdle;
                tcnt_q[c] <= '0;
            end
        end else begin
            cd_prev_q <= cd;
            for (int c = 0; c < 2; c++) begin
                case (st_q[c])
                    StIdle: begin
                        if (cd[c] && !cd_prev_q[c]) begin
                            busy_q[c] <= 1'b1;
                            tcnt_q[c] <= '0;
                            // A locked insertion is swallowed but still waits for release.
                            if (!coin_lock[c]) begin
                                st_q[c]    <= StActive;
                                pulse_q[c] <= 1'b1;
                            end else begin
                                st_q[c] <= StWaitRel;
                            end
                        end
                    end
                    StActive: begin
                        if (tick) begin
                            if (tcnt_q[c] == CW'(COIN_MS - 1)) begin
                                st_q[c]    <= StGap;
                                pulse_q[c] <= 1'b0;
                                tcnt_q[c]  <= '0;
                            end else begin
                                tcnt_q[c] <= tcnt_q[c] + CW'(1);
                            end
                        end
                    end
                    StGap: begin
                        if (tick) begin
                            if (tcnt_q[c] == CW'(GAP_MS - 1)) begin
                                st_q[c]   <= StWaitRel;
                                tcnt_q[c] <= '0;
                            end else begin
                                tcnt_q[c] <= tcnt_q[c] + CW'(1);
                            end
                        end
                    end
                    StWaitRel: begin
                        if (!cd[c]) begin
                            st_q[c]   <= StIdle;
                            busy_q[c] <= 1'b0;
                        end
                    end
                    default: begin
                        st_q[c]    <= StIdle;
                        pulse_q[c] <= 1'b0;
                        busy_q[c]  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign coin_pulse = pulse_q;
    assign coin_busy  = busy_q;

    // ---------------------------------------------------------------------
    // Saturating coin counter; both channels may accept in the same cycle
    // ---------------------------------------------------------------------
    logic [15:0] coin_count_q;
    logic [15:0] coin_count_d;
    logic [16:0] coin_sum;

    always_comb begin
        coin_sum     = {1'b0, coin_count_q} + 17'(accept[0]) + 17'(accept[1]);
        coin_count_d = coin_sum[16] ? 16'hFFFF : coin_sum[15:0];
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            coin_count_q <= '0;
        end else begin
            coin_count_q <= coin_count_d;
        end
    end

    assign coin_count = coin_count_q;

endmodule

// File: tb/tb_arcade_input_cond.sv
// Directed bench for arcade_input_cond with a coin scoreboard: the expected
// coin_count at each accepted coin is queued per channel when the press is
// driven, and popped when the matching coin_pulse rises.
module tb_arcade_input_cond;

    localparam int unsigned N_IN     = 8;
    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned DB_MS    = 3;
    localparam int unsigned COIN_MS  = 5;
    localparam int unsigned GAP_MS   = 2;

    logic            CLK = 1'b0;
    logic            RESET;
    logic [N_IN-1:0] in_raw;
    logic [1:0]      coin_raw;
    logic [1:0]      coin_lock;
    logic [N_IN-1:0] out_db;
    logic [1:0]      coin_pulse;
    logic [1:0]      coin_busy;
    logic [15:0]     coin_count;

    always #5 CLK = ~CLK;

    arcade_input_cond #(
        .N_IN    (N_IN),
        .TICK_DIV(TICK_DIV),
        .DB_MS   (DB_MS),
        .COIN_MS (COIN_MS),
        .GAP_MS  (GAP_MS)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .in_raw    (in_raw),
        .coin_raw  (coin_raw),
        .coin_lock (coin_lock),
        .out_db    (out_db),
        .coin_pulse(coin_pulse),
        .coin_busy (coin_busy),
        .coin_count(coin_count)
    );

    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];
    int          pulse_cnt [2];
    int          width     [2];
    logic [1:0]  pulse_prev = 2'b00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Pulse monitor: pops the scoreboard on each rising pulse, checks width on fall.
    always @(posedge CLK) begin
        #1;
        for (int c = 0; c < 2; c++) begin
            if (coin_pulse[c] === 1'b1 && pulse_prev[c] !== 1'b1) begin
                pulse_cnt[c]++;
                width[c] = 0;
                if (c == 0) begin
                    chk("pulse_expected_ch0", 32'(exp_q0.size() > 0), 1);
                    if (exp_q0.size() > 0) chk("count_at_pulse_ch0", coin_count, exp_q0.pop_front());
                end else begin
                    chk("pulse_expected_ch1", 32'(exp_q1.size() > 0), 1);
                    if (exp_q1.size() > 0) chk("count_at_pulse_ch1", coin_count, exp_q1.pop_front());
                end
            end
            if (coin_pulse[c] === 1'b1) width[c]++;
            if (coin_pulse[c] !== 1'b1 && pulse_prev[c] === 1'b1) begin
                chk($sformatf("pulse_width_17_20_ch%0d_w%0d", c, width[c]),
                    32'(width[c] >= 17 && width[c] <= 20), 1);
            end
        end
        pulse_prev = coin_pulse;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1;
        cycles(3);
        RESET = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((coin_busy !== 2'b00 || out_db !== '0) && n < 80) begin
            @(negedge CLK);
            n++;
        end
        chk(tag, 32'(coin_busy === 2'b00 && out_db === '0), 1);
    endtask

    task automatic wait_pulse(input int c, input logic level, input string tag);
        int n = 0;
        do begin
            @(posedge CLK);
            #1;
            n++;
        end while (coin_pulse[c] !== level && n < 60);
        chk(tag, 32'(coin_pulse[c] === level), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int p0;
        int p1;

        pulse_cnt[0] = 0;
        pulse_cnt[1] = 0;
        width[0]     = 0;
        width[1]     = 0;

        // Reset with everything held high: one coin per channel on release.
        RESET     = 1'b1;
        in_raw    = 8'hFF;
        coin_raw  = 2'b11;
        coin_lock = 2'b00;
        exp_q0.push_back(16'd2);
        exp_q1.push_back(16'd2);
        cycles(2);
        chk("reset_out_db", out_db, 0);
        chk("reset_coin_pulse", coin_pulse, 0);
        chk("reset_coin_busy", coin_busy, 0);
        chk("reset_coin_count", coin_count, 0);
        cycles(1);
        RESET = 1'b0;
        n = 0;
        while (out_db !== 8'hFF && n < 15) begin
            @(negedge CLK);
            n++;
        end
        chk("out_db_ff_after_reset", out_db, 8'hFF);
        cycles(50);
        chk("held_busy_after_reset", coin_busy, 2'b11);
        chk("count_after_reset", coin_count, 2);
        chk("pulses_ch0_after_reset", pulse_cnt[0], 1);
        chk("pulses_ch1_after_reset", pulse_cnt[1], 1);
        in_raw   = '0;
        coin_raw = 2'b00;
        wait_idle("idle_after_reset_release");

        // Glitch shorter than a tick is rejected.
        in_raw = 8'h01;
        cycles(3);
        in_raw = 8'h00;
        cycles(20);
        chk("glitch_rejected", out_db, 0);

        // Clean press: debounced 11..15 cycles after the raw edge.
        in_raw = 8'h01;
        n = 0;
        do begin
            @(posedge CLK);
            #1;
            n++;
        end while (out_db[0] !== 1'b1 && n < 30);
        chk($sformatf("db_latency_11_15_n%0d", n), 32'(n >= 11 && n <= 15), 1);
        cycles(5);
        chk("db_held", out_db, 8'h01);
        in_raw = 8'h00;
        wait_idle("db_released");

        // Single held coin yields exactly one pulse.
        do_reset();
        chk("count_cleared_by_reset", coin_count, 0);
        p0 = pulse_cnt[0];
        exp_q0.push_back(16'd1);
        coin_raw = 2'b01;
        cycles(200);
        chk("held_one_pulse", pulse_cnt[0] - p0, 1);
        chk("held_busy", coin_busy, 2'b01);
        chk("held_count", coin_count, 1);
        coin_raw = 2'b00;
        cycles(5);
        chk("busy_during_release_debounce", coin_busy, 2'b01);
        wait_idle("held_released");

        // Re-press while the first coin is still in ACTIVE/GAP is dropped.
        p0 = pulse_cnt[0];
        exp_q0.push_back(16'd2);
        coin_raw = 2'b01;
        wait_pulse(0, 1'b1, "fast_first_pulse_rise");
        @(negedge CLK);
        coin_raw = 2'b00;
        cycles(9);
        coin_raw = 2'b01;
        cycles(60);
        chk("fast_repeat_dropped_count", coin_count, 2);
        chk("fast_repeat_dropped_pulses", pulse_cnt[0] - p0, 1);
        chk("fast_repeat_busy_held", coin_busy, 2'b01);
        coin_raw = 2'b00;
        wait_idle("fast_repeat_released");
        exp_q0.push_back(16'd3);
        coin_raw = 2'b01;
        cycles(50);
        chk("after_gap_accepted_count", coin_count, 3);
        chk("after_gap_accepted_pulses", pulse_cnt[0] - p0, 2);
        coin_raw = 2'b00;
        wait_idle("after_gap_released");

        // Lockout rejects a press, but does not cut a running pulse.
        p1        = pulse_cnt[1];
        coin_lock = 2'b10;
        coin_raw  = 2'b10;
        cycles(40);
        chk("locked_busy", coin_busy, 2'b10);
        chk("locked_count", coin_count, 3);
        chk("locked_no_pulse", pulse_cnt[1] - p1, 0);
        coin_raw = 2'b00;
        wait_idle("locked_released");
        coin_lock = 2'b00;
        exp_q1.push_back(16'd4);
        coin_raw = 2'b10;
        wait_pulse(1, 1'b1, "lock_mid_pulse_rise");
        cycles(3);
        coin_lock = 2'b10;
        wait_pulse(1, 1'b0, "lock_mid_pulse_fall");
        chk("lock_mid_pulse_count", coin_count, 4);
        chk("lock_mid_pulse_pulses", pulse_cnt[1] - p1, 1);
        coin_raw = 2'b00;
        wait_idle("lock_mid_pulse_released");
        coin_lock = 2'b00;

        // Saturation with simultaneous acceptance on both channels.
        @(negedge CLK);
        force dut.coin_count_q = 16'hFFFE;
        @(negedge CLK);
        release dut.coin_count_q;
        chk("preload_fffe", coin_count, 16'hFFFE);
        p0 = pulse_cnt[0];
        p1 = pulse_cnt[1];
        exp_q0.push_back(16'hFFFF);
        exp_q1.push_back(16'hFFFF);
        coin_raw = 2'b11;
        cycles(40);
        chk("both_saturate_count", coin_count, 16'hFFFF);
        chk("both_pulse_ch0", pulse_cnt[0] - p0, 1);
        chk("both_pulse_ch1", pulse_cnt[1] - p1, 1);
        coin_raw = 2'b00;
        wait_idle("both_released");
        exp_q0.push_back(16'hFFFF);
        coin_raw = 2'b01;
        cycles(40);
        chk("stays_saturated", coin_count, 16'hFFFF);
        chk("saturated_pulse_ch0", pulse_cnt[0] - p0, 2);
        coin_raw = 2'b00;
        wait_idle("saturated_released");

        chk("scoreboard_ch0_drained", exp_q0.size(), 0);
        chk("scoreboard_ch1_drained", exp_q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
